// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit controller: FSM state type,
// default sizing constants and a width helper.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CREDIT,
      ST_VEND,
      ST_CHANGE
   } vend_state_t;

   localparam int CREDIT_W_DEF   = 10;
   localparam int MAX_CREDIT_DEF = 1000;

   // Index width that never collapses to zero bits for a single-entry set.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vend_edge_det.sv
// Parametrised-width rising-edge detector; one registered pulse per 0->1 transition.
module vend_edge_det #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] in_i,
   output logic [W-1:0] edge_o
);

   logic [W-1:0] prev_q;
   logic [W-1:0] edge_q;
   logic [W-1:0] edge_d;

   assign edge_d = in_i & ~prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= '0;
         edge_q <= '0;
      end else begin
         prev_q <= in_i;
         edge_q <= edge_d;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: coin accumulation, purchase debit, vend and change handshakes.
// Optional audit counters (sales_total, vend_count) are built when VEND_AUDIT_EN is defined.
module vend_credit_ctrl
   import vend_pkg::*;
#(
   parameter int                            NUM_COINS   = 2,
   parameter int                            NUM_ITEMS   = 2,
   parameter int                            CREDIT_W    = CREDIT_W_DEF,
   parameter int                            MAX_CREDIT  = MAX_CREDIT_DEF,
   parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = {10'd20, 10'd2},
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {10'd10, 10'd5},
   parameter int                            CHANGE_UNIT = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_COINS-1:0]              coin_in,
   input  logic [NUM_ITEMS-1:0]              item_req,
   input  logic                              cancel,
   input  logic                              vend_ack,
   input  logic                              change_ack,
   output logic [CREDIT_W-1:0]               credit,
   output logic                              buy_flag,
   output logic                              coin_reject,
   output logic                              req_deny,
   output logic                              vend_valid,
   output logic [clog2_min1(NUM_ITEMS)-1:0]  vend_item,
   output logic                              change_valid
`ifdef VEND_AUDIT_EN
   ,output logic [15:0]                      sales_total
   ,output logic [NUM_ITEMS*8-1:0]           vend_count
`endif
);

   localparam int ITEM_W = clog2_min1(NUM_ITEMS);
   localparam logic [CREDIT_W:0]   MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] UNIT    = CREDIT_W'(CHANGE_UNIT);

   function automatic logic params_ok();
      logic ok = 1'b1;
      if (CHANGE_UNIT <= 0) return 1'b0;
      for (int unsigned i = 0; i < NUM_COINS; i++)
         if (int'(COIN_VALUES[i*CREDIT_W +: CREDIT_W]) % CHANGE_UNIT != 0) ok = 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++)
         if (int'(ITEM_PRICES[i*CREDIT_W +: CREDIT_W]) % CHANGE_UNIT != 0) ok = 1'b0;
      if (MAX_CREDIT >= (1 << CREDIT_W)) ok = 1'b0;
      return ok;
   endfunction

   if (!params_ok()) begin : g_param_err
      $error("vend_credit_ctrl: coin values/prices must be multiples of CHANGE_UNIT and MAX_CREDIT must fit CREDIT_W");
   end

   logic [NUM_COINS-1:0] coin_e;
   logic [NUM_ITEMS-1:0] item_e;
   logic                 cancel_e;

   vend_edge_det #(.W(NUM_COINS)) u_coin_edge (
      .clk_i(clk), .rst_ni(reset), .in_i(coin_in), .edge_o(coin_e)
   );
   vend_edge_det #(.W(NUM_ITEMS)) u_item_edge (
      .clk_i(clk), .rst_ni(reset), .in_i(item_req), .edge_o(item_e)
   );
   vend_edge_det #(.W(1)) u_cancel_edge (
      .clk_i(clk), .rst_ni(reset), .in_i(cancel), .edge_o(cancel_e)
   );

   vend_state_t         state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic                buy_q;
   logic                coin_rej_q;
   logic                deny_q;
   logic                vend_valid_q;
   logic [ITEM_W-1:0]   vend_item_q;
   logic                change_valid_q;

   logic                coin_hit;
   logic                coin_multi;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_ok;
   logic [CREDIT_W-1:0] credit_d;
   logic                item_hit;
   logic [ITEM_W-1:0]   item_idx;
   logic [CREDIT_W-1:0] item_price;
   logic                item_ok;

   // Priority encoders scan downward so the lowest set index is the final winner.
   always_comb begin
      coin_hit   = |coin_e;
      coin_multi = (coin_e & (coin_e - NUM_COINS'(1))) != '0;
      coin_val   = '0;
      for (int unsigned i = NUM_COINS; i > 0; i--)
         if (coin_e[i-1]) coin_val = COIN_VALUES[(i-1)*CREDIT_W +: CREDIT_W];
      item_hit   = |item_e;
      item_idx   = '0;
      item_price = '0;
      for (int unsigned i = NUM_ITEMS; i > 0; i--)
         if (item_e[i-1]) begin
            item_idx   = ITEM_W'(i-1);
            item_price = ITEM_PRICES[(i-1)*CREDIT_W +: CREDIT_W];
         end
      coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
      coin_ok  = coin_sum <= MAX_SUM;
      credit_d = (coin_hit && coin_ok) ? coin_sum[CREDIT_W-1:0] : credit_q;
      item_ok  = credit_d >= item_price;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         buy_q          <= 1'b0;
         coin_rej_q     <= 1'b0;
         deny_q         <= 1'b0;
         vend_valid_q   <= 1'b0;
         vend_item_q    <= '0;
         change_valid_q <= 1'b0;
      end else begin
         coin_rej_q <= 1'b0;
         deny_q     <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_CREDIT: begin
               if (cancel_e) begin
                  coin_rej_q <= coin_hit;
                  if (credit_q != '0) begin
                     state_q        <= ST_CHANGE;
                     change_valid_q <= 1'b1;
                  end
               end else begin
                  coin_rej_q <= coin_hit && (coin_multi || !coin_ok);
                  if (item_hit && item_ok) begin
                     credit_q     <= credit_d - item_price;
                     vend_item_q  <= item_idx;
                     vend_valid_q <= 1'b1;
                     state_q      <= ST_VEND;
                  end else begin
                     credit_q <= credit_d;
                     deny_q   <= item_hit;
                     state_q  <= (credit_d != '0) ? ST_CREDIT : ST_IDLE;
                  end
               end
            end
            ST_VEND: begin
               coin_rej_q <= coin_hit;
               deny_q     <= item_hit;
               if (vend_ack) begin
                  vend_valid_q <= 1'b0;
                  buy_q        <= 1'b1;
                  state_q      <= (credit_q != '0) ? ST_CREDIT : ST_IDLE;
               end
            end
            ST_CHANGE: begin
               coin_rej_q <= coin_hit;
               deny_q     <= item_hit;
               if (change_ack) begin
                  if (credit_q <= UNIT) begin
                     credit_q       <= '0;
                     change_valid_q <= 1'b0;
                     buy_q          <= 1'b0;
                     state_q        <= ST_IDLE;
                  end else begin
                     credit_q <= credit_q - UNIT;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign credit       = credit_q;
   assign buy_flag     = buy_q;
   assign coin_reject  = coin_rej_q;
   assign req_deny     = deny_q;
   assign vend_valid   = vend_valid_q;
   assign vend_item    = vend_item_q;
   assign change_valid = change_valid_q;

`ifdef VEND_AUDIT_EN
   logic                   vend_done;
   logic [CREDIT_W-1:0]    vend_price;
   logic [16:0]            sales_sum;
   logic [15:0]            sales_q;
   logic [NUM_ITEMS*8-1:0] count_q;

   assign vend_done = (state_q == ST_VEND) && vend_ack;

   always_comb begin
      vend_price = '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++)
         if (ITEM_W'(i) == vend_item_q) vend_price = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
      sales_sum = {1'b0, sales_q} + 17'(vend_price);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sales_q <= '0;
         count_q <= '0;
      end else if (vend_done) begin
         sales_q <= sales_sum[16] ? '1 : sales_sum[15:0];
         for (int unsigned i = 0; i < NUM_ITEMS; i++)
            if (ITEM_W'(i) == vend_item_q && count_q[i*8 +: 8] != '1)
               count_q[i*8 +: 8] <= count_q[i*8 +: 8] + 8'd1;
      end
   end

   assign sales_total = sales_q;
   assign vend_count  = count_q;
`endif

endmodule
